// File: rtl/counter_sched_pkg.sv
// counter_sched shared definitions:
// command encoding, FSM states, settle counter width.
package counter_sched_pkg;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

    localparam int SCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/counter_sched_arb.sv
// rr_arb2: two-way round-robin arbiter.
// Holds the last-grant pointer; grant is one-hot {b, a}.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       update,
    input  logic       sel_b,
    output logic [1:0] grant
);

    logic last_b;

    // Pointer records who was issued; resets to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_b <= 1'b1;
        else if (update)
            last_b <= sel_b;
    end

    // Single requester wins outright; a tie goes to the one not served last.
    always_comb begin
        grant = 2'b00;
        if (a_valid && b_valid)
            grant = last_b ? 2'b01 : 2'b10;
        else if (a_valid)
            grant = 2'b01;
        else if (b_valid)
            grant = 2'b10;
    end

endmodule

// File: rtl/counter_sched.sv
// counter_sched: arbitrates two requesters and issues
// one registered strobe per command, then waits a settle gap.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WRAP   = 0,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [1:0]       a_cmd,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ack,
    input  logic             b_valid,
    input  logic [1:0]       b_cmd,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ack,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_inc,
    output logic             cnt_dec,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_ld_val,
    output logic             sat,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [SCNT_W-1:0] SETTLE_LD = SCNT_W'(SETTLE);

    state_t            state;
    logic [SCNT_W-1:0] scnt;
    logic [1:0]        grant;
    logic              pick_b;
    logic [1:0]        req_cmd;
    logic [WIDTH-1:0]  req_data;
    logic              blk_inc;
    logic              blk_dec;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .update  (state == ST_ISSUE),
        .sel_b   (b_ack),
        .grant   (grant)
    );

    // Select the winning command and evaluate the limit check.
    always_comb begin
        pick_b   = grant[1];
        req_cmd  = pick_b ? b_cmd  : a_cmd;
        req_data = pick_b ? b_data : a_data;
        blk_inc  = (WRAP == 0) && (cnt_val == MAX_VAL);
        blk_dec  = (WRAP == 0) && (cnt_val == '0);
    end

    // FSM; ack and strobes are registered at grant so they appear in ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            scnt       <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            cnt_inc    <= 1'b0;
            cnt_dec    <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_ld_val <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        a_ack <= !pick_b;
                        b_ack <= pick_b;
                        case (req_cmd)
                            CMD_INC: begin
                                cnt_inc <= !blk_inc;
                                sat     <= blk_inc;
                            end
                            CMD_DEC: begin
                                cnt_dec <= !blk_dec;
                                sat     <= blk_dec;
                            end
                            CMD_LOAD: begin
                                cnt_load   <= 1'b1;
                                cnt_ld_val <= req_data;
                            end
                            default: ;
                        endcase
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    a_ack      <= 1'b0;
                    b_ack      <= 1'b0;
                    cnt_inc    <= 1'b0;
                    cnt_dec    <= 1'b0;
                    cnt_load   <= 1'b0;
                    cnt_ld_val <= '0;
                    sat        <= 1'b0;
                    scnt       <= SETTLE_LD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    scnt <= scnt - 1'b1;
                    if (scnt <= 1) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: default, WRAP=1
// and SETTLE=3 instances share one stimulus stream.
module tb_counter_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid;
    logic [1:0] a_cmd, b_cmd;
    logic [7:0] a_data, b_data;
    logic [7:0] cnt_val;

    logic       a_ack0, b_ack0, inc0, dec0, load0, sat0, busy0;
    logic [7:0] ldv0;
    logic       a_ack1, b_ack1, inc1, dec1, load1, sat1, busy1;
    logic [7:0] ldv1;
    logic       a_ack2, b_ack2, inc2, dec2, load2, sat2, busy2;
    logic [7:0] ldv2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_sched #(.WIDTH(8), .WRAP(0), .SETTLE(1)) d0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_data(a_data), .a_ack(a_ack0),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_data(b_data), .b_ack(b_ack0),
        .cnt_val(cnt_val), .cnt_inc(inc0), .cnt_dec(dec0),
        .cnt_load(load0), .cnt_ld_val(ldv0), .sat(sat0), .busy(busy0)
    );

    counter_sched #(.WIDTH(8), .WRAP(1), .SETTLE(1)) d1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_data(a_data), .a_ack(a_ack1),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_data(b_data), .b_ack(b_ack1),
        .cnt_val(cnt_val), .cnt_inc(inc1), .cnt_dec(dec1),
        .cnt_load(load1), .cnt_ld_val(ldv1), .sat(sat1), .busy(busy1)
    );

    counter_sched #(.WIDTH(8), .WRAP(0), .SETTLE(3)) d2 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_data(a_data), .a_ack(a_ack2),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_data(b_data), .b_ack(b_ack2),
        .cnt_val(cnt_val), .cnt_inc(inc2), .cnt_dec(dec2),
        .cnt_load(load2), .cnt_ld_val(ldv2), .sat(sat2), .busy(busy2)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0;
        a_cmd = 2'b00; b_cmd = 2'b00;
        a_data = 8'h00; b_data = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        cnt_val = 8'd5;
        do_reset();

        // Reset state
        chk("rst_a_ack", a_ack0, 0);
        chk("rst_b_ack", b_ack0, 0);
        chk("rst_strobes", {inc0, dec0, load0}, 0);
        chk("rst_sat", sat0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ldv", ldv0, 0);

        // A INC alone, cnt_val=5
        a_valid = 1'b1; a_cmd = 2'b01;
        chk("t1_pre_ack", a_ack0, 0);
        step();
        chk("t1_a_ack", a_ack0, 1);
        chk("t1_inc", inc0, 1);
        chk("t1_b_ack", b_ack0, 0);
        chk("t1_busy1", busy0, 1);
        a_valid = 1'b0;
        step();
        chk("t1_a_ack_off", a_ack0, 0);
        chk("t1_inc_off", inc0, 0);
        chk("t1_busy2", busy0, 1);
        step();
        chk("t1_busy_off", busy0, 0);
        chk("t1_b_ack_off", b_ack0, 0);

        // Both valid: A=INC, B=DEC, grants alternate every 3 cycles
        do_reset();
        a_valid = 1'b1; a_cmd = 2'b01;
        b_valid = 1'b1; b_cmd = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            logic ea, eb;
            step();
            ea = (k % 3 == 1) && ((k / 3) % 2 == 0);
            eb = (k % 3 == 1) && ((k / 3) % 2 == 1);
            chk($sformatf("rr_a_ack_%0d", k), a_ack0, ea);
            chk($sformatf("rr_b_ack_%0d", k), b_ack0, eb);
            chk($sformatf("rr_inc_%0d", k), inc0, ea);
            chk($sformatf("rr_dec_%0d", k), dec0, eb);
        end

        // Saturation at 8'hFF with INC
        do_reset();
        cnt_val = 8'hFF;
        a_valid = 1'b1; a_cmd = 2'b01;
        step();
        chk("satinc_ack", a_ack0, 1);
        chk("satinc_inc", inc0, 0);
        chk("satinc_sat", sat0, 1);
        chk("wrapinc_inc", inc1, 1);
        chk("wrapinc_sat", sat1, 0);
        a_valid = 1'b0;
        step();
        chk("satinc_sat_off", sat0, 0);
        step(5);

        // Saturation at 8'h00 with DEC
        cnt_val = 8'h00;
        a_valid = 1'b1; a_cmd = 2'b10;
        step();
        chk("satdec_ack", a_ack0, 1);
        chk("satdec_dec", dec0, 0);
        chk("satdec_sat", sat0, 1);
        chk("wrapdec_dec", dec1, 1);
        chk("wrapdec_sat", sat1, 0);
        a_valid = 1'b0;
        step(6);

        // B LOAD 8'h3C
        cnt_val = 8'h10;
        b_valid = 1'b1; b_cmd = 2'b11; b_data = 8'h3C;
        chk("ld_pre_val", ldv0, 0);
        step();
        chk("ld_b_ack", b_ack0, 1);
        chk("ld_a_ack", a_ack0, 0);
        chk("ld_load", load0, 1);
        chk("ld_val", ldv0, 8'h3C);
        b_valid = 1'b0;
        step();
        chk("ld_load_off", load0, 0);
        chk("ld_val_off", ldv0, 0);
        step(5);

        // Reset asserted during ISSUE
        do_reset();
        cnt_val = 8'd5;
        a_valid = 1'b1; a_cmd = 2'b01;
        b_valid = 1'b1; b_cmd = 2'b10;
        step();
        chk("rmid_issue", a_ack0, 1);
        rst_n = 1'b0;
        step();
        chk("rmid_a_ack", a_ack0, 0);
        chk("rmid_b_ack", b_ack0, 0);
        chk("rmid_strobes", {inc0, dec0, load0}, 0);
        chk("rmid_busy", busy0, 0);
        rst_n = 1'b1;
        step();
        chk("rmid_tie_a", a_ack0, 1);
        chk("rmid_tie_b", b_ack0, 0);
        idle_inputs();
        step(6);

        // SETTLE=3: A holds valid, second ack 5 cycles after first
        do_reset();
        cnt_val = 8'd5;
        a_valid = 1'b1; a_cmd = 2'b01;
        step();
        chk("s3_ack1", a_ack2, 1);
        chk("s3_inc1", inc2, 1);
        a_cmd = 2'b10;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk($sformatf("s3_gap_ack_%0d", k), a_ack2, 0);
            chk($sformatf("s3_busy_%0d", k), busy2, (k <= 4) ? 1 : 0);
        end
        step();
        chk("s3_ack2", a_ack2, 1);
        chk("s3_dec2", dec2, 1);
        chk("s3_b_ack", b_ack2, 0);
        idle_inputs();
        step(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
